regfile_write_arbiter: RTL and testbench

// - Shares the single write port of the 16x8 register file among NUM_REQ requesters.
// - Grants are round-robin, one per cycle, using a req/gnt handshake.
// - A clear sequencer zeroes all 16 registers on command by sweeping Addr_WR 0..15.
// - Sits between the requesting units and the register file's Addr_WR/WR/DIN inputs.

---
 rtl/regfile_pkg.sv | 12 +
 rtl/rr_arbiter.sv | 42 ++++
 rtl/regfile_write_arbiter.sv | 108 ++++++++++
 tb/tb_regfile_write_arbiter.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and sizes for the register-file write path.
// Pure declarations: no logic, no latency.
package regfile_pkg;

    localparam int ADDR_W   = 4;
    localparam int DATA_W   = 8;
    localparam int NUM_REGS = 16;

    typedef enum logic {IDLE, CLEAR} wr_state_t;
    typedef logic [ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot gnt, combinational from req, 0 cycles.
// The pointer moves past the winner only when advance is asserted; no backpressure of its own.
module rr_arbiter #(
    parameter int N = 3
) (
    input  logic         Clock,
    input  logic         Reset,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] gnt
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr_q, ptr_d, idx;
    logic          found;

    // Scan from the pointer, wrapping modulo N; the first requester found wins.
    always_comb begin
        gnt   = '0;
        ptr_d = ptr_q;
        found = 1'b0;
        idx   = '0;
        for (int off = 0; off < N; off++) begin
            idx = PW'((int'(ptr_q) + off) % N);
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                ptr_d    = PW'((int'(ptr_q) + off + 1) % N);
            end
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            ptr_q <= '0;
        end else if (advance) begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the 16x8 register-file write port among NUM_REQ requesters and runs a zeroing sweep.
// Grant is combinational, the write reaches WR/Addr_WR/DIN one edge later; requests stall (held) while Busy.
module regfile_write_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = 4,
    parameter int DATA_W  = 8
) (
    input  logic                      Clock,
    input  logic                      Reset,
    input  logic [NUM_REQ-1:0]        Req,
    input  logic [NUM_REQ*ADDR_W-1:0] Req_Addr,
    input  logic [NUM_REQ*DATA_W-1:0] Req_Data,
    output logic [NUM_REQ-1:0]        Gnt,
    input  logic                      Clear_Req,
    output logic                      Busy,
    output logic                      Clear_Done,
    output logic                      WR,
    output logic [ADDR_W-1:0]         Addr_WR,
    output logic [DATA_W-1:0]         DIN
);

    import regfile_pkg::*;

    localparam logic [ADDR_W-1:0] LAST_CNT = ADDR_W'(NUM_REGS - 1);

    wr_state_t           state_q;
    logic [ADDR_W-1:0]   cnt_q;
    logic                wr_q;
    logic                done_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   din_q;

    logic                grant_en;
    logic [NUM_REQ-1:0]  arb_req;
    logic                gnt_any;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_data;

    // A clear request in IDLE takes priority over every requester that cycle.
    assign grant_en = Reset && (state_q == IDLE) && !Clear_Req;
    assign arb_req  = Req & {NUM_REQ{grant_en}};
    assign gnt_any  = |Gnt;

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .Clock   (Clock),
        .Reset   (Reset),
        .req     (arb_req),
        .advance (gnt_any),
        .gnt     (Gnt)
    );

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (Gnt[i]) begin
                sel_addr = Req_Addr[i*ADDR_W +: ADDR_W];
                sel_data = Req_Data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            done_q  <= 1'b0;
            addr_q  <= '0;
            din_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (Clear_Req) begin
                        state_q <= CLEAR;
                        cnt_q   <= '0;
                        wr_q    <= 1'b0;
                    end else if (gnt_any) begin
                        wr_q   <= 1'b1;
                        addr_q <= sel_addr;
                        din_q  <= sel_data;
                    end else begin
                        wr_q <= 1'b0;
                    end
                end
                CLEAR: begin
                    wr_q   <= 1'b1;
                    addr_q <= cnt_q;
                    din_q  <= '0;
                    cnt_q  <= cnt_q + 1'b1;
                    if (cnt_q == LAST_CNT) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign Busy       = (state_q == CLEAR);
    assign Clear_Done = done_q;
    assign WR         = wr_q;
    assign Addr_WR    = addr_q;
    assign DIN        = din_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Randomized and directed bench for regfile_write_arbiter against a queue-based requester/regfile model.
module tb_regfile_write_arbiter;
    import regfile_pkg::*;

    localparam int N  = 3;
    localparam int AW = 4;
    localparam int DW = 8;

    typedef struct packed {
        reg_addr_t     a;
        logic [DW-1:0] d;
    } txn_t;

    logic            Clock = 1'b0;
    logic            Reset;
    logic [N-1:0]    Req;
    logic [N*AW-1:0] Req_Addr;
    logic [N*DW-1:0] Req_Data;
    logic [N-1:0]    Gnt;
    logic            Clear_Req;
    logic            Busy;
    logic            Clear_Done;
    logic            WR;
    logic [AW-1:0]   Addr_WR;
    logic [DW-1:0]   DIN;

    always #5 Clock = ~Clock;

    regfile_write_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .Req        (Req),
        .Req_Addr   (Req_Addr),
        .Req_Data   (Req_Data),
        .Gnt        (Gnt),
        .Clear_Req  (Clear_Req),
        .Busy       (Busy),
        .Clear_Done (Clear_Done),
        .WR         (WR),
        .Addr_WR    (Addr_WR),
        .DIN        (DIN)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: pending request queues, rotating priority, remaining sweep writes.
    txn_t          rq[N][$];
    logic          clr;
    int            ptr;
    int            clear_left;
    logic          m_wr, m_done;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_din;
    logic [DW-1:0] m_mem[16];
    logic [DW-1:0] d_mem[16];

    logic [N-1:0]  s_gnt;
    logic          s_wr, s_busy, s_done;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_din;

    function automatic int model_grant();
        if (!Reset || clear_left > 0 || clr) return -1;
        for (int off = 0; off < N; off++) begin
            int k;
            k = (ptr + off) % N;
            if (rq[k].size() > 0) return k;
        end
        return -1;
    endfunction

    task automatic model_reset();
        ptr = 0; clear_left = 0;
        m_wr = 1'b0; m_done = 1'b0; m_addr = '0; m_din = '0;
    endtask

    task automatic model_edge(input int k);
        if (m_wr) m_mem[m_addr] = m_din;
        m_done = 1'b0;
        if (clear_left > 0) begin
            m_wr = 1'b1;
            m_addr = AW'(16 - clear_left);
            m_din = '0;
            clear_left--;
            m_done = (clear_left == 0);
        end else if (clr) begin
            clear_left = 16;
            m_wr = 1'b0;
        end else if (k >= 0) begin
            m_wr = 1'b1;
            m_addr = rq[k][0].a;
            m_din = rq[k][0].d;
            void'(rq[k].pop_front());
            ptr = (k + 1) % N;
        end else begin
            m_wr = 1'b0;
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            Req[i] = (rq[i].size() > 0);
            if (rq[i].size() > 0) begin
                Req_Addr[i*AW +: AW] = rq[i][0].a;
                Req_Data[i*DW +: DW] = rq[i][0].d;
            end else begin
                Req_Addr[i*AW +: AW] = AW'($urandom_range(0, 15));
                Req_Data[i*DW +: DW] = DW'($urandom_range(0, 255));
            end
        end
        Clear_Req = clr;
    endtask

    task automatic step();
        int k;
        drive();
        if (!Reset) model_reset();
        k = model_grant();
        @(negedge Clock);
        s_gnt = Gnt; s_wr = WR; s_addr = Addr_WR; s_din = DIN; s_busy = Busy; s_done = Clear_Done;
        chk("gnt",  32'(Gnt), (k < 0) ? 32'd0 : 32'(1 << k));
        chk("wr",   32'(WR), 32'(m_wr));
        chk("addr", 32'(Addr_WR), 32'(m_addr));
        chk("din",  32'(DIN), 32'(m_din));
        chk("busy", 32'(Busy), 32'(clear_left > 0));
        chk("done", 32'(Clear_Done), 32'(m_done));
        @(posedge Clock);
        if (s_wr === 1'b1) d_mem[s_addr] = s_din;
        if (Reset) model_edge(k);
        #1;
    endtask

    initial begin
        int guard;
        for (int a = 0; a < 16; a++) begin
            m_mem[a] = '0;
            d_mem[a] = '0;
        end
        Reset = 1'b0; clr = 1'b0;
        Req = '0; Req_Addr = '0; Req_Data = '0; Clear_Req = 1'b0;
        model_reset();
        step(); step();
        Reset = 1'b1;
        step();
        chk("reset_outs", 32'({s_gnt, s_wr, s_addr, s_din, s_busy, s_done}), 32'd0);

        // All three requesters held: strict rotation 001, 010, 100, ...
        for (int i = 0; i < N; i++) begin
            rq[i].push_back('{reg_addr_t'(i + 1), DW'($urandom_range(0, 255))});
            rq[i].push_back('{reg_addr_t'(i + 1), DW'($urandom_range(0, 255))});
        end
        for (int c = 0; c < 6; c++) begin
            step();
            chk("rr_seq", 32'(s_gnt), 32'(1 << (c % 3)));
        end

        rq[0].push_back('{reg_addr_t'(5), 8'hA5});
        step();
        chk("single_gnt", 32'(s_gnt), 32'd1);
        step();
        chk("single_wr", 32'({s_wr, s_addr, s_din}), 32'({1'b1, 4'd5, 8'hA5}));

        clr = 1'b1; step(); clr = 1'b0;
        for (int c = 0; c <= 16; c++) begin
            step();
            if (c >= 1) chk("sweep_wr", 32'({s_wr, s_addr, s_din}), 32'({1'b1, 4'(c - 1), 8'h00}));
            chk("sweep_busy", 32'(s_busy), 32'(c < 16));
            chk("sweep_done", 32'(s_done), 32'(c == 16));
        end

        clr = 1'b1; step(); clr = 1'b0;
        for (int c = 0; c <= 16; c++) begin
            if (c == 4) rq[1].push_back('{reg_addr_t'(9), 8'h3C});
            if (c == 8) clr = 1'b1;
            if (c == 9) clr = 1'b0;
            step();
            chk("clr_stall", 32'(s_gnt), (c == 16) ? 32'd2 : 32'd0);
        end
        step();
        chk("clr_wr", 32'({s_wr, s_addr, s_din}), 32'({1'b1, 4'd9, 8'h3C}));

        clr = 1'b1; step(); clr = 1'b0;
        for (int c = 0; c < 7; c++) step();
        rq[2].push_back('{reg_addr_t'(12), 8'h5A});
        Reset = 1'b0;
        step();
        chk("rst_mid", 32'({s_gnt, s_wr, s_addr, s_din, s_busy, s_done}), 32'd0);
        step();
        Reset = 1'b1;
        for (int c = 0; c < 20; c++) begin
            step();
            chk("rst_no_done", 32'(s_done), 32'd0);
        end

        for (int cyc = 0; cyc < 800; cyc++) begin
            for (int i = 0; i < N; i++)
                if (rq[i].size() < 2 && $urandom_range(0, 2) == 0)
                    rq[i].push_back('{reg_addr_t'($urandom_range(0, 15)), DW'($urandom_range(0, 255))});
            clr = ($urandom_range(0, 49) == 0);
            step();
        end
        clr = 1'b0;
        guard = 0;
        while ((rq[0].size() + rq[1].size() + rq[2].size() > 0 || clear_left > 0) && guard < 200) begin
            step();
            guard++;
        end
        chk("drain", 32'(guard < 200), 32'd1);
        step(); step();
        for (int a = 0; a < 16; a++) chk("mem", 32'(d_mem[a]), 32'(m_mem[a]));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
